illegal_op_trap: RTL

ILLEGAL_OP_TRAP -- requirements
Module: illegal_op_trap

---
 rtl/illegal_op_trap_if.sv | 29 ++
 rtl/illegal_op_trap.sv | 57 +++++
 2 files changed

// File: rtl/illegal_op_trap_if.sv
// illegal_op_trap_if: instruction/trap handshake between the decode pipeline and the illegal-op trap unit.
interface illegal_op_trap_if #(
    parameter int OP_SIZE  = 5,
    parameter int PC_SIZE  = 16,
    parameter int CNT_SIZE = 8
);
    logic                instr_valid;
    logic [OP_SIZE-1:0]  op;
    logic [PC_SIZE-1:0]  pc;
    logic                trap_ack;
    logic                invalid_op;
    logic                err;
    logic                trap_req;
    logic                stall;
    logic [PC_SIZE-1:0]  epc;
    logic [OP_SIZE-1:0]  bad_op;
    logic [CNT_SIZE-1:0] illegal_cnt;
    logic                double_fault;

    modport master (
        output instr_valid, op, pc, trap_ack,
        input  invalid_op, err, trap_req, stall, epc, bad_op, illegal_cnt, double_fault
    );

    modport slave (
        input  instr_valid, op, pc, trap_ack,
        output invalid_op, err, trap_req, stall, epc, bad_op, illegal_cnt, double_fault
    );
endinterface

// File: rtl/illegal_op_trap.sv
// illegal_op_trap: detects opcodes outside VALID_MASK, raises a trap and tracks
// the faulting PC/opcode, an illegal-instruction count and nested faults.
module illegal_op_trap #(
    parameter int                    OP_SIZE    = 5,
    parameter int                    PC_SIZE    = 16,
    parameter int                    CNT_SIZE   = 8,
    parameter logic [2**OP_SIZE-1:0] VALID_MASK = '1,
    parameter logic [OP_SIZE-1:0]    RTI_OP     = OP_SIZE'(3)
) (
    input logic               clk,
    input logic               rst,
    illegal_op_trap_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, TRAP, HANDLER} stateT;
    stateT state, stateNext;
    logic opLegal, accepted, acceptIllegal, acceptRti;

    assign opLegal       = VALID_MASK[bus.op];
    assign bus.invalid_op = bus.instr_valid & ~opLegal;
    // Instructions presented while the trap is pending are not consumed
    assign accepted      = bus.instr_valid & (state != TRAP);
    assign acceptIllegal = accepted & ~opLegal;
    assign acceptRti     = accepted & opLegal & (bus.op == RTI_OP);

    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else     state <= stateNext;

    always_comb
        stateNext = (state == IDLE) ? (acceptIllegal ? TRAP : IDLE) :
                    (state == TRAP) ? (bus.trap_ack ? HANDLER : TRAP) :
                                      (acceptRti ? IDLE : HANDLER);

    always_comb begin
        bus.trap_req = state == TRAP;
        bus.stall    = state == TRAP;
    end

    always_ff @(posedge clk)
        if (rst) begin
            bus.err          <= 1'b0;
            bus.epc          <= '0;
            bus.bad_op       <= '0;
            bus.illegal_cnt  <= '0;
            bus.double_fault <= 1'b0;
        end else begin
            bus.err <= acceptIllegal;
            if (acceptIllegal && state == IDLE) begin
                bus.epc    <= bus.pc;
                bus.bad_op <= bus.op;
            end
            if (acceptIllegal && bus.illegal_cnt != '1)
                bus.illegal_cnt <= bus.illegal_cnt + 1'b1;
            if (acceptIllegal && state == HANDLER)
                bus.double_fault <= 1'b1;
        end
endmodule
